// File: rtl/diff_commit_sender_if.sv
// Commit-record bus between the writeback stage, the difftest bridge and the trap status.
// master = record producer / bridge side, slave = diff_commit_sender.
interface diff_commit_sender_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_skip;
  logic        in_wen;
  logic [7:0]  in_wdest;
  logic [63:0] in_wdata;
  logic [7:0]  in_store_mask;
  logic [63:0] in_store_paddr;
  logic [63:0] in_store_data;

  logic        out_valid;
  logic [7:0]  out_index;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_skip;
  logic        out_wen;
  logic [7:0]  out_wdest;
  logic [63:0] out_wdata;
  logic [7:0]  out_store_valid;
  logic [63:0] out_store_paddr;
  logic [63:0] out_store_data;

  logic        trap_valid;
  logic [63:0] trap_code;
  logic        timeout;

  modport master (
    output in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
           in_store_mask, in_store_paddr, in_store_data,
    input  in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
           out_wdest, out_wdata, out_store_valid, out_store_paddr, out_store_data,
           trap_valid, trap_code, timeout
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
           in_store_mask, in_store_paddr, in_store_data,
    output in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
           out_wdest, out_wdata, out_store_valid, out_store_paddr, out_store_data,
           trap_valid, trap_code, timeout
  );
endinterface

// File: rtl/diff_commit_sender.sv
// Buffers committed instructions in a small FIFO and replays them one per cycle to the
// difftest bridge; halts on ebreak (after draining) or on an idle timeout.
//
// state | meaning
// RUN   | accepting records, emitting queued ones, idle timer running
// DRAIN | ebreak accepted; no new records, emitting what is left
// HALT  | terminal until reset; trap outputs frozen
module diff_commit_sender #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input logic                 clock,
  input logic                 reset,
  diff_commit_sender_if.slave bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
  localparam logic [31:0] IDLE_MAX = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic [7:0]  store_mask;
    logic [63:0] store_paddr;
    logic [63:0] store_data;
  } rec_t;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  state_t        state, state_next;
  rec_t          mem [DEPTH];
  rec_t          rec_in, out_rec;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    seq, out_index;
  logic          out_valid;
  logic [63:0]   shadow_a0, a0_next, trap_code;
  logic [31:0]   idle_cnt;
  logic          trap_valid, timeout;
  logic          in_ready, push, pop, ebreak_acc, timeout_hit;

  assign rec_in = '{pc: bus.in_pc, instr: bus.in_instr, skip: bus.in_skip, wen: bus.in_wen,
                    wdest: bus.in_wdest, wdata: bus.in_wdata, store_mask: bus.in_store_mask,
                    store_paddr: bus.in_store_paddr, store_data: bus.in_store_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (ebreak_acc)       state_next = DRAIN;
        else if (timeout_hit) state_next = HALT;
      end
      DRAIN:   if (count == '0 && !out_valid) state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  // ebreak wins over a coinciding timeout; an emission this cycle also defers it
  always_comb begin
    in_ready    = (state == RUN) && (count != FULL);
    push        = bus.in_valid && in_ready;
    ebreak_acc  = push && (bus.in_instr == EBREAK);
    pop         = (state != HALT) && (count != '0);
    timeout_hit = (state == RUN) && !ebreak_acc && !pop && (idle_cnt == IDLE_MAX);
    a0_next     = (out_valid && out_rec.wen && out_rec.wdest == 8'd10) ? out_rec.wdata
                                                                       : shadow_a0;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_rec    <= '0;
      shadow_a0  <= '0;
      idle_cnt   <= '0;
      trap_valid <= 1'b0;
      trap_code  <= '0;
      timeout    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;

      out_valid <= pop;
      if (pop) begin
        out_rec   <= mem[rd_ptr];
        out_index <= seq;
        seq       <= seq + 8'd1;
      end else begin
        out_rec   <= '0;
        out_index <= '0;
      end

      shadow_a0 <= a0_next;

      if (state != RUN || ebreak_acc || pop) idle_cnt <= '0;
      else if (!timeout_hit)                 idle_cnt <= idle_cnt + 32'd1;

      // a0_next folds in a write from the record leaving the output stage this cycle
      if (state != HALT && state_next == HALT) begin
        trap_valid <= 1'b1;
        trap_code  <= a0_next;
        timeout    <= timeout_hit;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid;
  assign bus.out_index       = out_index;
  assign bus.out_pc          = out_rec.pc;
  assign bus.out_instr       = out_rec.instr;
  assign bus.out_skip        = out_rec.skip;
  assign bus.out_wen         = out_rec.wen;
  assign bus.out_wdest       = out_rec.wdest;
  assign bus.out_wdata       = out_rec.wdata;
  assign bus.out_store_valid = out_rec.store_mask;
  assign bus.out_store_paddr = out_rec.store_paddr;
  assign bus.out_store_data  = out_rec.store_data;
  assign bus.trap_valid      = trap_valid;
  assign bus.trap_code       = trap_code;
  assign bus.timeout         = timeout;
endmodule

// File: tb/tb_diff_commit_sender.sv
// Bench for diff_commit_sender: queue-based reference model checked every cycle,
// plus directed checks for latency, index wrap, ebreak drain, timeout and reset.
module tb_diff_commit_sender;
  localparam int          DEPTH  = 4;
  localparam int          TMO    = 16;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic [7:0]  store_mask;
    logic [63:0] store_paddr;
    logic [63:0] store_data;
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  diff_commit_sender_if bus ();

  diff_commit_sender #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int errors   = 0;
  int emit_cnt = 0;
  logic [7:0] last_idx;

  // reference model: phase 0 = accepting, 1 = draining after ebreak, 2 = halted
  rec_t        m_q[$];
  bit          m_valid;
  rec_t        m_out;
  logic [7:0]  m_idx, m_seq;
  logic [63:0] m_a0, m_code;
  int          m_phase, m_idle;
  bit          m_trap, m_to;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t observed();
    rec_t o;
    o.pc          = bus.out_pc;
    o.instr       = bus.out_instr;
    o.skip        = bus.out_skip;
    o.wen         = bus.out_wen;
    o.wdest       = bus.out_wdest;
    o.wdata       = bus.out_wdata;
    o.store_mask  = bus.out_store_valid;
    o.store_paddr = bus.out_store_paddr;
    o.store_data  = bus.out_store_data;
    return o;
  endfunction

  function automatic bit model_ready();
    return (m_phase == 0) && (m_q.size() < DEPTH);
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    int   k;
    r.pc    = {$urandom, $urandom};
    r.instr = $urandom;
    if (r.instr == EBREAK) r.instr = 32'h0000_0013;
    r.skip  = 1'($urandom_range(0, 1));
    r.wen   = 1'($urandom_range(0, 1));
    k       = $urandom_range(0, 3);
    r.wdest = (k == 0) ? 8'd10 : (k == 1) ? 8'd0 : 8'($urandom);
    r.wdata = {$urandom, $urandom};
    r.store_mask  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
    r.store_paddr = {$urandom, $urandom};
    r.store_data  = {$urandom, $urandom};
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_valid = 0; m_out = '0; m_idx = '0; m_seq = '0;
    m_a0 = '0; m_code = '0; m_phase = 0; m_idle = 0; m_trap = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic v, input rec_t r);
    bit acc, eb, emit;
    int nphase;
    rec_t nr;
    acc    = v && model_ready();
    eb     = acc && (r.instr == EBREAK);
    emit   = (m_phase != 2) && (m_q.size() > 0);
    nphase = m_phase;
    if (m_valid && m_out.wen && m_out.wdest == 8'd10) m_a0 = m_out.wdata;
    if (m_phase == 0) begin
      if (eb) begin nphase = 1; m_idle = 0; end
      else if (emit) m_idle = 0;
      else if (m_idle == TMO - 1) begin nphase = 2; m_to = 1; end
      else m_idle++;
    end else if (m_phase == 1) begin
      if (m_q.size() == 0 && !m_valid) nphase = 2;
    end
    if (nphase == 2 && m_phase != 2) begin m_trap = 1; m_code = m_a0; end
    m_phase = nphase;
    if (emit) begin
      nr = m_q.pop_front();
      m_valid = 1; m_out = nr; m_idx = m_seq; m_seq = m_seq + 8'd1;
    end else begin
      m_valid = 0; m_out = '0; m_idx = '0;
    end
    if (acc) m_q.push_back(r);
  endtask

  task automatic check_outputs();
    if (bus.out_valid === 1'b1) begin emit_cnt++; last_idx = bus.out_index; end
    chk("out_valid",  320'(bus.out_valid),  320'(m_valid));
    chk("out_index",  320'(bus.out_index),  320'(m_idx));
    chk("out_record", 320'(observed()),     320'(m_out));
    chk("trap_valid", 320'(bus.trap_valid), 320'(m_trap));
    chk("trap_code",  320'(bus.trap_code),  320'(m_code));
    chk("timeout",    320'(bus.timeout),    320'(m_to));
  endtask

  task automatic drive(input logic v, input rec_t r);
    bus.in_valid       = v;
    bus.in_pc          = r.pc;
    bus.in_instr       = r.instr;
    bus.in_skip        = r.skip;
    bus.in_wen         = r.wen;
    bus.in_wdest       = r.wdest;
    bus.in_wdata       = r.wdata;
    bus.in_store_mask  = r.store_mask;
    bus.in_store_paddr = r.store_paddr;
    bus.in_store_data  = r.store_data;
  endtask

  task automatic step(input logic v, input rec_t r);
    drive(v, r);
    @(negedge clock);
    chk("in_ready", 320'(bus.in_ready), 320'(model_ready()));
    @(posedge clock);
    model_edge(v, r);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", 320'(bus.in_ready), 320'(1'b1));
    drive(1'b0, '0);
    @(posedge clock);
    model_edge(1'b0, '0);
    #1;
    check_outputs();
  endtask

  initial begin
    rec_t r;
    rec_t nop;
    nop = '0;
    drive(1'b0, nop);
    #2;
    do_reset();

    // single record: visible two edges after acceptance
    r = rand_rec();
    r.pc = 64'h8000_0000; r.wen = 1'b1; r.wdest = 8'd10; r.wdata = 64'd5; r.store_mask = 8'd0;
    step(1'b1, r);
    chk("latency_edge1_valid", 320'(bus.out_valid), 320'(1'b0));
    step(1'b0, nop);
    chk("latency_edge2_valid", 320'(bus.out_valid), 320'(1'b1));
    chk("first_index",         320'(bus.out_index), 320'(8'd0));
    chk("first_pc",            320'(bus.out_pc),    320'(64'h8000_0000));
    chk("first_wdata",         320'(bus.out_wdata), 320'(64'd5));
    idle(2);

    // 256 more back-to-back records: index wraps back to 0
    emit_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      r = rand_rec();
      if (i == 5) r.store_mask = 8'hFF;
      step(1'b1, r);
    end
    idle(3);
    chk("burst_emit_count", 320'(emit_cnt), 320'(256));
    chk("wrap_index",       320'(last_idx), 320'(8'd0));

    // a0 = 0, then ebreak behind queued records: all emitted, trap code 0
    emit_cnt = 0;
    r = rand_rec(); r.wen = 1'b1; r.wdest = 8'd10; r.wdata = 64'd0;
    step(1'b1, r);
    r = rand_rec(); r.wdest = 8'd3; step(1'b1, r);
    r = rand_rec(); r.wdest = 8'd4; step(1'b1, r);
    r = rand_rec(); r.wdest = 8'd5; r.instr = EBREAK; step(1'b1, r);
    for (int i = 0; i < 20 && bus.trap_valid !== 1'b1; i++) step(1'b0, nop);
    chk("drain_trap_valid", 320'(bus.trap_valid), 320'(1'b1));
    chk("drain_trap_code",  320'(bus.trap_code),  320'(64'd0));
    chk("drain_timeout",    320'(bus.timeout),    320'(1'b0));
    chk("drain_emit_count", 320'(emit_cnt),       320'(4));
    emit_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1, rand_rec());
    chk("halt_no_emission", 320'(emit_cnt), 320'(0));

    // idle timeout after 16 idle edges
    do_reset();
    idle(TMO - 2);
    chk("timeout_early", 320'(bus.trap_valid), 320'(1'b0));
    idle(1);
    chk("timeout_trap_valid", 320'(bus.trap_valid), 320'(1'b1));
    chk("timeout_flag",       320'(bus.timeout),    320'(1'b1));

    // ebreak on the timeout cycle wins
    do_reset();
    idle(TMO - 2);
    r = rand_rec(); r.instr = EBREAK; r.wen = 1'b0;
    step(1'b1, r);
    chk("ebreak_vs_timeout_trap", 320'(bus.trap_valid), 320'(1'b0));
    idle(4);
    chk("ebreak_vs_timeout_halt", 320'(bus.trap_valid), 320'(1'b1));
    chk("ebreak_vs_timeout_flag", 320'(bus.timeout),    320'(1'b0));

    // reset in the middle of a drain
    do_reset();
    step(1'b1, rand_rec());
    r = rand_rec(); r.instr = EBREAK; step(1'b1, r);
    do_reset();
    chk("reset_mid_drain_valid", 320'(bus.out_valid), 320'(1'b0));
    emit_cnt = 0;
    idle(5);
    chk("reset_mid_drain_no_emit", 320'(emit_cnt), 320'(0));

    // randomized traffic with rare ebreaks and idle gaps
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        r = rand_rec();
        if ($urandom_range(0, 99) == 0) r.instr = EBREAK;
        if ($urandom_range(0, 59) == 0) idle(TMO + 2);
        step(1'($urandom_range(0, 3) != 0), r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
